cpu_mc_param: RTL and testbench

- Parametrised multi-cycle successor to the current 4-state CPU core.
- Fixed 32-bit instruction word; configurable data width, register count and address width.
- Memory port uses a req/ack handshake with wait-state tolerance instead of fixed-latency fetch.
- Adds immediates, load/store, conditional branch, jump and HALT; stalls correctly on slow memory.

---
 rtl/cpu_mc_pkg.sv | 54 +++++
 rtl/cpu_mc_param_regfile.sv | 34 +++
 rtl/cpu_mc_param.sv | 179 +++++++++++++++++
 tb/tb_cpu_mc_param.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mc_pkg.sv
// cpu_mc_pkg: opcodes, FSM states, instruction field layout and the
// immediate sign-extension helper shared by the multi-cycle core.
package cpu_mc_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_NOT  = 4'h5,
    OP_SHL  = 4'h6,
    OP_SHR  = 4'h7,
    OP_ADDI = 4'h8,
    OP_MUL  = 4'h9,
    OP_LW   = 4'hA,
    OP_SW   = 4'hB,
    OP_BEQ  = 4'hC,
    OP_JMP  = 4'hD,
    OP_ILL  = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_FETCH_WAIT,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_MEM_WAIT,
    ST_WRITEBACK,
    ST_HALTED
  } cpu_state_t;

  localparam int OP_LSB  = 28;
  localparam int RD_LSB  = 24;
  localparam int RS1_LSB = 20;
  localparam int RS2_LSB = 16;
  localparam int IMM_LSB = 0;
  localparam int FIELD_W = 4;
  localparam int IMM_W   = 16;

  // Sign-extends a 16-bit immediate and masks it to data_w bits; callers
  // cast the 64-bit result down to their own width.
  function automatic logic [63:0] sext16(input logic [15:0] imm, input int data_w);
    logic [63:0] v;
    v = {{48{imm[15]}}, imm};
    if (data_w < 64) begin
      v = v & ((64'd1 << data_w) - 64'd1);
    end
    return v;
  endfunction

endpackage

// File: rtl/cpu_mc_param_regfile.sv
// regfile_param: NREGS x DATA_W register file with two combinational read
// ports and one synchronous write port; r0 is hard-wired to zero.
module regfile_param #(
  parameter int NREGS  = 16,
  parameter int DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  input  logic [$clog2(NREGS)-1:0] raddr2,
  output logic [DATA_W-1:0]        rdata1,
  output logic [DATA_W-1:0]        rdata2,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata
);

  logic [DATA_W-1:0] regs [NREGS];

  // Clear every entry on reset; later writes aimed at r0 are dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/cpu_mc_param.sv
// cpu_mc_param: parametrised multi-cycle core with a req/ack memory port.
// Each instruction walks FETCH -> DECODE -> EXECUTE -> [MEM] -> WRITEBACK,
// and the WAIT states absorb any number of memory wait cycles.
module cpu_mc_param
  import cpu_mc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int ADDR_W = 8,
  parameter int PC_W   = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              retire,
  output logic              halted,
  output logic              illegal,
  output logic [PC_W-1:0]   pc_out
);

  localparam int RI_W = $clog2(NREGS);
  localparam int SH_W = $clog2(DATA_W);

  cpu_state_t        state, next_state;
  logic [PC_W-1:0]   pc, next_pc, pc_target;
  logic [31:0]       ir;
  logic [DATA_W-1:0] op_a, op_b, result, alu_res, imm_ext, rd1, rd2;
  logic [ADDR_W-1:0] ea;
  logic              halted_q, illegal_q;
  opcode_t           op;
  logic [RI_W-1:0]   rd_idx, rs1_idx, rs2_idx;
  logic [15:0]       imm;
  logic              writes_rd;

  assign op        = opcode_t'(ir[OP_LSB +: FIELD_W]);
  assign rd_idx    = ir[RD_LSB +: RI_W];
  assign rs1_idx   = ir[RS1_LSB +: RI_W];
  assign rs2_idx   = ir[RS2_LSB +: RI_W];
  assign imm       = ir[IMM_LSB +: IMM_W];
  assign imm_ext   = DATA_W'(sext16(imm, DATA_W));
  assign writes_rd = (op <= OP_LW);

  regfile_param #(
    .NREGS  (NREGS),
    .DATA_W (DATA_W)
  ) u_rf (
    .clock   (clock),
    .reset_n (reset_n),
    .raddr1  (rs1_idx),
    .raddr2  (rs2_idx),
    .rdata1  (rd1),
    .rdata2  (rd2),
    .we      ((state == ST_WRITEBACK) && writes_rd),
    .waddr   (rd_idx),
    .wdata   (result)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; HALTED is terminal until reset.
  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH:      next_state = ST_FETCH_WAIT;
      ST_FETCH_WAIT: if (mem_ack) next_state = ST_DECODE;
      ST_DECODE:     next_state = (op == OP_ILL || op == OP_HALT) ? ST_HALTED : ST_EXECUTE;
      ST_EXECUTE:    next_state = (op == OP_LW || op == OP_SW) ? ST_MEM : ST_WRITEBACK;
      ST_MEM:        next_state = ST_MEM_WAIT;
      ST_MEM_WAIT:   if (mem_ack) next_state = ST_WRITEBACK;
      ST_WRITEBACK:  next_state = ST_FETCH;
      ST_HALTED:     next_state = ST_HALTED;
      default:       next_state = ST_FETCH;
    endcase
  end

  // Memory port outputs; mem_req is gated by reset_n so it falls the moment reset is applied.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_FETCH, ST_FETCH_WAIT: begin
        mem_req  = reset_n;
        mem_addr = pc[ADDR_W-1:0];
      end
      ST_MEM, ST_MEM_WAIT: begin
        mem_req   = reset_n;
        mem_we    = (op == OP_SW);
        mem_addr  = ea;
        mem_wdata = op_b;
      end
      default: ;
    endcase
  end

  assign retire  = (state == ST_WRITEBACK);
  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign pc_out  = pc;

  // ALU result for the register-writing ops.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_NOT:  alu_res = ~op_a;
      OP_SHL:  alu_res = op_a << op_b[SH_W-1:0];
      OP_SHR:  alu_res = op_a >> op_b[SH_W-1:0];
      OP_ADDI: alu_res = op_a + imm_ext;
      OP_MUL:  alu_res = op_a * op_b;
      default: alu_res = '0;
    endcase
  end

  // Successor PC: taken BEQ is PC-relative, JMP is an absolute zero-extended target.
  always_comb begin
    pc_target = pc + PC_W'(1);
    if (op == OP_BEQ && op_a == op_b) begin
      pc_target = pc + PC_W'(sext16(imm, PC_W));
    end else if (op == OP_JMP) begin
      pc_target = PC_W'(imm);
    end
  end

  // Datapath registers, each loaded in the state that produces its value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= '0;
      next_pc   <= '0;
      ir        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      result    <= '0;
      ea        <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        ST_FETCH_WAIT: if (mem_ack) ir <= mem_rdata;
        ST_DECODE: begin
          op_a <= rd1;
          op_b <= rd2;
          if (op == OP_ILL) begin
            illegal_q <= 1'b1;
            halted_q  <= 1'b1;
          end else if (op == OP_HALT) begin
            halted_q <= 1'b1;
          end
        end
        ST_EXECUTE: begin
          result  <= alu_res;
          ea      <= ADDR_W'(op_a + imm_ext);
          next_pc <= pc_target;
        end
        ST_MEM_WAIT: if (mem_ack && op == OP_LW) result <= DATA_W'(mem_rdata);
        ST_WRITEBACK: pc <= next_pc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mc_param.sv
// tb_cpu_mc_param: directed programs for cpu_mc_param against a word memory
// model with programmable ack delay, plus a 16-bit / 8-register instance.
module tb_cpu_mc_param;

  localparam logic [31:0] HALT_W = 32'hF000_0000;

  logic        clock;
  logic        reset_n;
  logic        manual_ack;
  int          ack_delay;
  int          cycle;
  int          n_cmp;
  int          n_err;

  logic        mem_req, mem_we, mem_ack, retire, halted, illegal;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [15:0] pc_out;
  logic        resp_ack;
  int          resp_cnt;

  logic        mem_req2, mem_we2, mem_ack2, retire2, halted2, illegal2;
  logic [7:0]  mem_addr2;
  logic [15:0] mem_wdata2, pc_out2;
  logic [31:0] mem_rdata2;
  int          resp_cnt2;

  logic [31:0] image  [256];
  logic [31:0] mem    [256];
  logic [31:0] image2 [256];
  logic [31:0] mem2   [256];

  int          rt[$];
  logic [7:0]  fetch_log[$];
  logic        req_prev;
  logic [7:0]  hold_addr;
  logic        hold_we;
  logic [31:0] hold_wdata;
  int          stab_err;

  cpu_mc_param #(.DATA_W(32), .NREGS(16), .ADDR_W(8), .PC_W(16)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .retire    (retire),
    .halted    (halted),
    .illegal   (illegal),
    .pc_out    (pc_out)
  );

  cpu_mc_param #(.DATA_W(16), .NREGS(8), .ADDR_W(8), .PC_W(16)) dut16 (
    .clock     (clock),
    .reset_n   (reset_n),
    .mem_req   (mem_req2),
    .mem_we    (mem_we2),
    .mem_addr  (mem_addr2),
    .mem_wdata (mem_wdata2),
    .mem_rdata (mem_rdata2),
    .mem_ack   (mem_ack2),
    .retire    (retire2),
    .halted    (halted2),
    .illegal   (illegal2),
    .pc_out    (pc_out2)
  );

  assign mem_ack = resp_ack | manual_ack;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  // Memory model for the main core: ack arrives ack_delay cycles into the wait state.
  always @(negedge clock) begin
    if (!reset_n) begin
      resp_ack <= 1'b0;
      resp_cnt <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= image[i];
    end else if (resp_ack) begin
      resp_ack <= 1'b0;
      resp_cnt <= 0;
    end else if (mem_req) begin
      resp_cnt <= resp_cnt + 1;
      if (resp_cnt >= ack_delay) begin
        resp_ack  <= 1'b1;
        mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
      end
    end else begin
      resp_cnt <= 0;
    end
  end

  // Memory model for the 16-bit core, single-cycle ack.
  always @(negedge clock) begin
    if (!reset_n) begin
      mem_ack2  <= 1'b0;
      resp_cnt2 <= 0;
      for (int i = 0; i < 256; i++) mem2[i] <= image2[i];
    end else if (mem_ack2) begin
      mem_ack2  <= 1'b0;
      resp_cnt2 <= 0;
    end else if (mem_req2) begin
      resp_cnt2 <= resp_cnt2 + 1;
      if (resp_cnt2 >= 1) begin
        mem_ack2   <= 1'b1;
        mem_rdata2 <= mem2[mem_addr2];
        if (mem_we2) mem2[mem_addr2] <= 32'(mem_wdata2);
      end
    end else begin
      resp_cnt2 <= 0;
    end
  end

  // Monitor: retire timestamps, request start addresses, request stability.
  always @(negedge clock) begin
    if (!reset_n) begin
      rt.delete();
      fetch_log.delete();
      req_prev <= 1'b0;
      stab_err <= 0;
    end else begin
      if (retire) rt.push_back(cycle);
      if (mem_req && !req_prev) begin
        fetch_log.push_back(mem_addr);
        hold_addr  <= mem_addr;
        hold_we    <= mem_we;
        hold_wdata <= mem_wdata;
      end else if (mem_req && (mem_addr != hold_addr || mem_we != hold_we || mem_wdata != hold_wdata)) begin
        stab_err <= stab_err + 1;
      end
      req_prev <= mem_req;
    end
  end

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clearImage();
    for (int i = 0; i < 256; i++) image[i] = HALT_W;
  endtask

  // Hold reset long enough for the memory models to reload, then release just after a rising edge.
  task automatic applyStimulus(input int delay);
    reset_n   = 1'b0;
    ack_delay = delay;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic waitHalt(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clock);
      if (halted) break;
    end
    #1;
    checkOutput("halt_reached", 64'(halted), 64'd1);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    cycle      = 0;
    manual_ack = 1'b0;
    ack_delay  = 1;
    reset_n    = 1'b0;

    for (int i = 0; i < 256; i++) image2[i] = HALT_W;
    image2[0] = enc(4'h8, 4'h1, 4'h0, 4'h0, 16'd1);
    image2[1] = enc(4'h8, 4'h2, 4'h0, 4'h0, 16'd15);
    image2[2] = enc(4'h6, 4'h3, 4'h1, 4'h2, 16'd0);
    image2[3] = enc(4'hB, 4'h0, 4'h0, 4'h3, 16'h0020);
    image2[4] = enc(4'h8, 4'hA, 4'h0, 4'h0, 16'h1234);
    image2[5] = enc(4'hB, 4'h0, 4'h0, 4'h2, 16'h0021);
    image2[6] = enc(4'h8, 4'hB, 4'h0, 4'h0, 16'hFFFF);
    image2[7] = enc(4'hB, 4'h0, 4'h0, 4'h3, 16'h0022);

    // Reset values.
    clearImage();
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
    checkOutput("rst_mem_we", 64'(mem_we), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    checkOutput("rst_retire", 64'(retire), 64'd0);
    checkOutput("rst_halted", 64'(halted), 64'd0);
    checkOutput("rst_illegal", 64'(illegal), 64'd0);
    checkOutput("rst_pc", 64'(pc_out), 64'd0);

    // Arithmetic, r0 protection and store-back, single-cycle ack.
    $display("[TB] arithmetic program");
    clearImage();
    image[0]  = enc(4'h8, 4'h1, 4'h0, 4'h0, 16'd5);
    image[1]  = enc(4'h8, 4'h2, 4'h0, 4'h0, 16'hFFFD);
    image[2]  = enc(4'h0, 4'h3, 4'h1, 4'h2, 16'd0);
    image[3]  = enc(4'h9, 4'h4, 4'h1, 4'h1, 16'd0);
    image[4]  = enc(4'hB, 4'h0, 4'h0, 4'h3, 16'h0020);
    image[5]  = enc(4'hB, 4'h0, 4'h0, 4'h4, 16'h0021);
    image[6]  = enc(4'h8, 4'h0, 4'h0, 4'h0, 16'd7);
    image[7]  = enc(4'hB, 4'h0, 4'h0, 4'h0, 16'h0022);
    image[8]  = enc(4'h1, 4'h5, 4'h2, 4'h1, 16'd0);
    image[9]  = enc(4'hB, 4'h0, 4'h0, 4'h5, 16'h0023);
    image[10] = enc(4'h7, 4'h6, 4'h5, 4'h1, 16'd0);
    image[11] = enc(4'hB, 4'h0, 4'h0, 4'h6, 16'h0024);
    image[12] = enc(4'h4, 4'h7, 4'h5, 4'h6, 16'd0);
    image[13] = enc(4'hB, 4'h0, 4'h0, 4'h7, 16'h0025);
    image[14] = enc(4'h2, 4'h8, 4'h5, 4'h6, 16'd0);
    image[15] = enc(4'hB, 4'h0, 4'h0, 4'h8, 16'h0026);
    image[34] = 32'h0000_0055;
    applyStimulus(1);
    waitHalt(400);
    checkOutput("ar_add", 64'(mem[8'h20]), 64'd2);
    checkOutput("ar_mul", 64'(mem[8'h21]), 64'd25);
    checkOutput("ar_r0", 64'(mem[8'h22]), 64'd0);
    checkOutput("ar_sub", 64'(mem[8'h23]), 64'hFFFF_FFF8);
    checkOutput("ar_shr", 64'(mem[8'h24]), 64'h07FF_FFFF);
    checkOutput("ar_xor", 64'(mem[8'h25]), 64'hF800_0007);
    checkOutput("ar_and", 64'(mem[8'h26]), 64'h07FF_FFF8);
    checkOutput("ar_retires", 64'(rt.size()), 64'd16);
    checkOutput("ar_alu_cycles", 64'(rt[1] - rt[0]), 64'd5);
    checkOutput("ar_mul_cycles", 64'(rt[3] - rt[2]), 64'd5);
    checkOutput("ar_sw_cycles", 64'(rt[4] - rt[3]), 64'd7);
    checkOutput("ar_pc", 64'(pc_out), 64'd16);
    checkOutput("ar_illegal", 64'(illegal), 64'd0);

    // 16-bit / 8-register instance ran the same span.
    checkOutput("p16_halted", 64'(halted2), 64'd1);
    checkOutput("p16_shl15", 64'(mem2[8'h20]), 64'h8000);
    checkOutput("p16_rd_alias", 64'(mem2[8'h21]), 64'h1234);
    checkOutput("p16_sext", 64'(mem2[8'h22]), 64'hFFFF);
    checkOutput("p16_pc", 64'(pc_out2), 64'd8);

    // Load/store with a 3-cycle ack delay, including address wrap.
    $display("[TB] load/store program");
    clearImage();
    image[0]  = enc(4'hA, 4'h1, 4'h0, 4'h0, 16'h0030);
    image[1]  = enc(4'hB, 4'h0, 4'h0, 4'h1, 16'h0010);
    image[2]  = enc(4'hA, 4'h5, 4'h0, 4'h0, 16'h0010);
    image[3]  = enc(4'hB, 4'h0, 4'h0, 4'h5, 16'h0011);
    image[4]  = enc(4'hB, 4'h0, 4'h1, 4'h5, 16'h0051);
    image[48] = 32'hDEAD_BEEF;
    applyStimulus(3);
    waitHalt(400);
    checkOutput("ls_sw", 64'(mem[8'h10]), 64'hDEAD_BEEF);
    checkOutput("ls_lw", 64'(mem[8'h11]), 64'hDEAD_BEEF);
    checkOutput("ls_wrap", 64'(mem[8'h40]), 64'hDEAD_BEEF);
    checkOutput("ls_sw_cycles", 64'(rt[1] - rt[0]), 64'd11);
    checkOutput("ls_lw_cycles", 64'(rt[2] - rt[1]), 64'd11);
    checkOutput("ls_stable", 64'(stab_err), 64'd0);
    checkOutput("ls_retires", 64'(rt.size()), 64'd5);

    // Branches and jump to the top of the PC space.
    $display("[TB] branch program");
    clearImage();
    image[0] = enc(4'h8, 4'h1, 4'h0, 4'h0, 16'd1);
    image[1] = enc(4'h8, 4'h2, 4'h0, 4'h0, 16'd1);
    image[2] = enc(4'hD, 4'h0, 4'h0, 4'h0, 16'd6);
    image[4] = enc(4'h8, 4'h2, 4'h2, 4'h0, 16'd1);
    image[5] = enc(4'hD, 4'h0, 4'h0, 4'h0, 16'd6);
    image[6] = enc(4'hC, 4'h0, 4'h1, 4'h2, 16'hFFFE);
    image[7] = enc(4'hD, 4'h0, 4'h0, 4'h0, 16'hFFFF);
    applyStimulus(1);
    waitHalt(400);
    begin
      logic [7:0] exp_fetch [9];
      exp_fetch = '{8'h00, 8'h01, 8'h02, 8'h06, 8'h04, 8'h05, 8'h06, 8'h07, 8'hFF};
      checkOutput("br_fetch_count", 64'(fetch_log.size()), 64'd9);
      for (int i = 0; i < 9; i++) begin
        checkOutput($sformatf("br_fetch_%0d", i), 64'(fetch_log[i]), 64'(exp_fetch[i]));
      end
    end
    checkOutput("br_pc", 64'(pc_out), 64'hFFFF);
    checkOutput("br_retires", 64'(rt.size()), 64'd8);

    // Illegal opcode: sticky flags, no retire, no further requests, ack ignored.
    $display("[TB] illegal opcode program");
    clearImage();
    image[0] = enc(4'h8, 4'h1, 4'h0, 4'h0, 16'd3);
    image[1] = 32'hE000_0000;
    applyStimulus(1);
    waitHalt(100);
    repeat (20) @(negedge clock);
    manual_ack = 1'b1;
    @(negedge clock);
    manual_ack = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checkOutput("ill_flag", 64'(illegal), 64'd1);
    checkOutput("ill_halted", 64'(halted), 64'd1);
    checkOutput("ill_retires", 64'(rt.size()), 64'd1);
    checkOutput("ill_reqs", 64'(fetch_log.size()), 64'd2);
    checkOutput("ill_pc", 64'(pc_out), 64'd1);
    checkOutput("ill_req_low", 64'(mem_req), 64'd0);

    // Reset while a fetch is outstanding.
    $display("[TB] reset mid-fetch");
    clearImage();
    applyStimulus(10);
    @(posedge clock);
    #3;
    checkOutput("mid_req_before", 64'(mem_req), 64'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_req_async", 64'(mem_req), 64'd0);
    manual_ack = 1'b1;
    @(posedge clock);
    #1 manual_ack = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    checkOutput("mid_refetch_req", 64'(mem_req), 64'd1);
    checkOutput("mid_refetch_addr", 64'(mem_addr), 64'd0);
    waitHalt(100);
    checkOutput("mid_pc", 64'(pc_out), 64'd0);
    checkOutput("mid_retires", 64'(rt.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
